n64_pi_address_latch: RTL and testbench

- Front end of the N64 Parallel Interface (PI) cartridge bus, running in the FPGA clock domain.
- Synchronises the asynchronous AD16/ALE_H/ALE_L/READ_n/WRITE_n pins and reassembles the 32-bit bus address from the two multiplexed halves.
- Auto-increments the address by 2 after each 16-bit transfer and emits single-cycle read/write requests.
- o_address feeds the bank decoder's i_address directly; the downstream bank logic returns read data through i_read_data.

---
 rtl/n64_pi_address_latch_pkg.sv | 19 +
 rtl/n64_pi_address_latch_sync.sv | 31 +++
 rtl/n64_pi_address_latch.sv | 148 ++++++++++++++
 tb/tb_n64_pi_address_latch.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/n64_pi_address_latch_pkg.sv
// Shared definitions for the N64 PI address front end: FSM encoding and the
// per-transfer address step.
package n64_pi_address_latch_pkg;

  typedef enum logic [1:0] {
    PI_IDLE   = 2'd0,
    PI_ADDR_H = 2'd1,
    PI_ADDR_L = 2'd2,
    PI_DATA   = 2'd3
  } piState_e;

  localparam logic [31:0] PI_ADDR_INC = 32'd2;

  // Full 32-bit wrap so 0xFFFF_FFFE steps to 0x0000_0000.
  function automatic logic [31:0] incAddress(input logic [31:0] addr);
    return addr + PI_ADDR_INC;
  endfunction

endpackage

// File: rtl/n64_pi_address_latch_sync.sv
// Multi-stage pin synchroniser with a per-bit reset value so each pin can
// come out of reset at its bus-idle level. STAGES must be at least 2.
module n64_pi_sync #(
  parameter int               WIDTH       = 1,
  parameter int               STAGES      = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= RESET_VALUE;
      end
    end else begin
      stage_q[0] <= i_async;
      for (int i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign o_sync = stage_q[STAGES-1];

endmodule

// File: rtl/n64_pi_address_latch.sv
// PI cartridge bus front end: synchronises the PI pins, rebuilds the 32-bit
// address from the two ALE phases and issues single-cycle read/write requests.
module n64_pi_address_latch
  import n64_pi_address_latch_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_n64_ale_h,
  input  logic        i_n64_ale_l,
  input  logic        i_n64_read_n,
  input  logic        i_n64_write_n,
  input  logic [15:0] i_n64_ad,
  output logic [15:0] o_n64_ad,
  output logic        o_n64_ad_oe,
  output logic [31:0] o_address,
  output logic        o_address_valid,
  output logic        o_read_request,
  input  logic [15:0] i_read_data,
  output logic        o_write_request,
  output logic [15:0] o_write_data
);

  logic [3:0]  ctrlSync;
  logic [15:0] sAd;
  logic        sAleH, sAleL, sRd, sWr;
  logic [1:0]  aleBits;

  // AD goes through the same depth as the strobes so data stays aligned.
  n64_pi_sync #(.WIDTH(4), .STAGES(SYNC_STAGES), .RESET_VALUE(4'b0011)) uCtrlSync (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_async   ({i_n64_ale_h, i_n64_ale_l, i_n64_read_n, i_n64_write_n}),
    .o_sync    (ctrlSync)
  );

  n64_pi_sync #(.WIDTH(16), .STAGES(SYNC_STAGES), .RESET_VALUE(16'h0000)) uAdSync (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_async   (i_n64_ad),
    .o_sync    (sAd)
  );

  assign {sAleH, sAleL, sRd, sWr} = ctrlSync;
  assign aleBits = {sAleH, sAleL};

  piState_e    state_q;
  logic [31:0] address_q;
  logic [15:0] adOut_q;
  logic [15:0] writeData_q;
  logic        adOe_q;
  logic        addressValid_q;
  logic        readRequest_q;
  logic        writeRequest_q;
  logic        incPending_q;
  logic        prevRd_q;
  logic        prevWr_q;

  logic rdFall, rdRise, wrRise;
  assign rdFall = prevRd_q & ~sRd;
  assign rdRise = ~prevRd_q & sRd;
  assign wrRise = ~prevWr_q & sWr;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q        <= PI_IDLE;
      address_q      <= '0;
      adOut_q        <= '0;
      writeData_q    <= '0;
      adOe_q         <= 1'b0;
      addressValid_q <= 1'b0;
      readRequest_q  <= 1'b0;
      writeRequest_q <= 1'b0;
      incPending_q   <= 1'b0;
      prevRd_q       <= 1'b1;
      prevWr_q       <= 1'b1;
    end else begin
      readRequest_q  <= 1'b0;
      writeRequest_q <= 1'b0;
      incPending_q   <= 1'b0;
      prevRd_q       <= sRd;
      prevWr_q       <= sWr;

      // A write bumps the address one cycle after its request pulse.
      if (incPending_q) begin
        address_q <= incAddress(address_q);
      end

      if (aleBits == 2'b11) begin
        state_q        <= PI_ADDR_H;
        addressValid_q <= 1'b0;
        adOe_q         <= 1'b0;
      end else begin
        case (state_q)
          PI_IDLE: begin
            state_q <= PI_IDLE;
          end
          PI_ADDR_H: begin
            if (aleBits == 2'b01) begin
              state_q           <= PI_ADDR_L;
              address_q[31:16]  <= sAd;
            end else if (aleBits == 2'b00) begin
              state_q <= PI_IDLE;
            end
          end
          PI_ADDR_L: begin
            if (aleBits == 2'b00) begin
              state_q          <= PI_DATA;
              address_q[15:0]  <= {sAd[15:1], 1'b0};
              addressValid_q   <= 1'b1;
            end
          end
          PI_DATA: begin
            if (aleBits == 2'b01) begin
              state_q        <= PI_ADDR_L;
              addressValid_q <= 1'b0;
              adOe_q         <= 1'b0;
            end else if (rdFall) begin
              readRequest_q <= 1'b1;
              adOut_q       <= i_read_data;
              adOe_q        <= 1'b1;
            end else if (rdRise) begin
              adOe_q    <= 1'b0;
              address_q <= incAddress(address_q);
            end else if (wrRise && sRd && prevRd_q) begin
              writeData_q    <= sAd;
              writeRequest_q <= 1'b1;
              incPending_q   <= 1'b1;
            end
          end
          default: begin
            state_q <= PI_IDLE;
          end
        endcase
      end
    end
  end

  assign o_n64_ad        = adOut_q;
  assign o_n64_ad_oe     = adOe_q;
  assign o_address       = address_q;
  assign o_address_valid = addressValid_q;
  assign o_read_request  = readRequest_q;
  assign o_write_request = writeRequest_q;
  assign o_write_data    = writeData_q;

endmodule

// File: tb/tb_n64_pi_address_latch.sv
// Directed bench for the PI address front end: address latch, burst read,
// write, wrap, illegal overlap, abort, ALE glitch and async reset.
module tb_n64_pi_address_latch;

  logic        clk = 1'b0;
  logic        rstN = 1'b1;
  logic        aleH = 1'b0;
  logic        aleL = 1'b0;
  logic        rdN = 1'b1;
  logic        wrN = 1'b1;
  logic [15:0] adIn = 16'h0000;
  logic [15:0] readData = 16'h0000;
  logic [15:0] adOut;
  logic        adOe;
  logic [31:0] address;
  logic        addressValid;
  logic        readReq;
  logic        writeReq;
  logic [15:0] writeData;

  int checks = 0;
  int errors = 0;

  n64_pi_address_latch #(.SYNC_STAGES(2)) dut (
    .i_clk           (clk),
    .i_reset_n       (rstN),
    .i_n64_ale_h     (aleH),
    .i_n64_ale_l     (aleL),
    .i_n64_read_n    (rdN),
    .i_n64_write_n   (wrN),
    .i_n64_ad        (adIn),
    .o_n64_ad        (adOut),
    .o_n64_ad_oe     (adOe),
    .o_address       (address),
    .o_address_valid (addressValid),
    .o_read_request  (readReq),
    .i_read_data     (readData),
    .o_write_request (writeReq),
    .o_write_data    (writeData)
  );

  always #5 clk = ~clk;

  // Request monitor: one queue entry per pulse plus a count of high cycles.
  logic [31:0] rdAddr [$];
  logic [31:0] wrAddr [$];
  logic [15:0] wrDataSeen [$];
  int          rdHigh = 0;
  int          wrHigh = 0;
  logic        rdPrev = 1'b0;
  logic        wrPrev = 1'b0;

  always @(negedge clk) begin
    if (readReq) begin
      rdHigh++;
      if (!rdPrev) rdAddr.push_back(address);
    end
    if (writeReq) begin
      wrHigh++;
      if (!wrPrev) begin
        wrAddr.push_back(address);
        wrDataSeen.push_back(writeData);
      end
    end
    rdPrev = readReq;
    wrPrev = writeReq;
  end

  task automatic clearMonitor();
    rdAddr.delete();
    wrAddr.delete();
    wrDataSeen.delete();
    rdHigh = 0;
    wrHigh = 0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic h, input logic l, input logic r,
                               input logic w, input logic [15:0] ad, input int cycles);
    aleH = h;
    aleL = l;
    rdN  = r;
    wrN  = w;
    adIn = ad;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  // Real PI order: high half held while ALE_H falls, then low half, then ALE_L falls.
  task automatic latchAddress(input logic [15:0] hi, input logic [15:0] lo);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, hi, 4);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, hi, 4);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, lo, 4);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, lo, 4);
  endtask

  function automatic logic [31:0] rdAt(input int i);
    return (i < rdAddr.size()) ? rdAddr[i] : 32'hDEAD_DEAD;
  endfunction

  initial begin
    #1 rstN = 1'b0;
    #2;
    $display("[TB] reset state");
    checkOutput("rst_address", address, 32'h0);
    checkOutput("rst_valid", 32'(addressValid), 32'h0);
    checkOutput("rst_oe", 32'(adOe), 32'h0);
    checkOutput("rst_ad", 32'(adOut), 32'h0);
    checkOutput("rst_rdreq", 32'(readReq), 32'h0);
    checkOutput("rst_wrreq", 32'(writeReq), 32'h0);
    checkOutput("rst_wrdata", 32'(writeData), 32'h0);
    repeat (2) @(posedge clk);
    #1 rstN = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 3);

    $display("[TB] address latch");
    clearMonitor();
    latchAddress(16'h1000, 16'h0040);
    checkOutput("latch_address", address, 32'h1000_0040);
    checkOutput("latch_valid", 32'(addressValid), 32'h1);
    checkOutput("latch_no_rd", 32'(rdHigh), 32'h0);
    checkOutput("latch_no_wr", 32'(wrHigh), 32'h0);

    $display("[TB] burst read");
    readData = 16'hA5A5;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h0040, 4);
      checkOutput("burst_oe_high", 32'(adOe), 32'h1);
      checkOutput("burst_ad_drive", 32'(adOut), 32'h0000_A5A5);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 16'h0040, 4);
      checkOutput("burst_oe_low", 32'(adOe), 32'h0);
    end
    checkOutput("burst_pulses", 32'(rdAddr.size()), 32'd4);
    checkOutput("burst_high_cycles", 32'(rdHigh), 32'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput("burst_req_addr", rdAt(i), 32'h1000_0040 + 32'(2 * i));
    end
    checkOutput("burst_final_addr", address, 32'h1000_0048);
    checkOutput("burst_no_wr", 32'(wrHigh), 32'h0);

    $display("[TB] write");
    clearMonitor();
    latchAddress(16'h1E00, 16'h0010);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'hBEEF, 4);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 16'hBEEF, 4);
    checkOutput("wr_pulses", 32'(wrAddr.size()), 32'd1);
    checkOutput("wr_high_cycles", 32'(wrHigh), 32'd1);
    checkOutput("wr_req_addr", (wrAddr.size() > 0) ? wrAddr[0] : 32'hDEAD_DEAD, 32'h1E00_0010);
    checkOutput("wr_req_data", (wrDataSeen.size() > 0) ? 32'(wrDataSeen[0]) : 32'hDEAD_DEAD,
                32'h0000_BEEF);
    checkOutput("wr_final_addr", address, 32'h1E00_0012);
    checkOutput("wr_no_rd", 32'(rdHigh), 32'h0);

    $display("[TB] odd address and wrap");
    clearMonitor();
    latchAddress(16'hFFFF, 16'hFFFF);
    checkOutput("wrap_latched", address, 32'hFFFF_FFFE);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 3);
    checkOutput("rd_latency", 32'(readReq), 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1);
    checkOutput("rd_pulse_end", 32'(readReq), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 4);
    checkOutput("wrap_address", address, 32'h0000_0000);

    $display("[TB] read and write strobes overlapping");
    clearMonitor();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h1234, 4);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h1234, 4);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 16'h1234, 4);
    checkOutput("overlap_rd", 32'(rdAddr.size()), 32'd1);
    checkOutput("overlap_no_wr", 32'(wrHigh), 32'h0);
    checkOutput("overlap_address", address, 32'h0000_0002);

    $display("[TB] abort during read");
    latchAddress(16'h2000, 16'h0100);
    clearMonitor();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h0100, 4);
    checkOutput("abort_oe_before", 32'(adOe), 32'h1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 16'h3000, 4);
    checkOutput("abort_oe", 32'(adOe), 32'h0);
    checkOutput("abort_valid", 32'(addressValid), 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 16'h3000, 4);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 16'h3000, 4);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 16'h3000, 4);
    checkOutput("abort_no_inc", address, 32'h2000_0100);
    checkOutput("abort_no_req", 32'(rdAddr.size()), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 16'h3000, 4);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 16'h0300, 4);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 16'h0300, 4);
    checkOutput("abort_relatch", address, 32'h3000_0300);
    checkOutput("abort_relatch_valid", 32'(addressValid), 32'h1);

    $display("[TB] ALE_L glitch");
    clearMonitor();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 16'h4444, 4);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 16'h4444, 4);
    checkOutput("glitch_address", address, 32'h3000_0300);
    checkOutput("glitch_valid", 32'(addressValid), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h4444, 4);
    checkOutput("glitch_idle_oe", 32'(adOe), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 16'h4444, 4);
    checkOutput("glitch_idle_no_req", 32'(rdHigh), 32'h0);

    $display("[TB] reset during write strobe");
    latchAddress(16'h1E00, 16'h0020);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h1234, 4);
    #2 rstN = 1'b0;
    #1;
    checkOutput("mid_rst_address", address, 32'h0);
    checkOutput("mid_rst_valid", 32'(addressValid), 32'h0);
    checkOutput("mid_rst_ad", 32'(adOut), 32'h0);
    checkOutput("mid_rst_wrdata", 32'(writeData), 32'h0);
    wrN = 1'b1;
    clearMonitor();
    repeat (2) @(posedge clk);
    #1 rstN = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 16'h1234, 10);
    checkOutput("post_rst_no_wr", 32'(wrHigh), 32'h0);
    checkOutput("post_rst_no_rd", 32'(rdHigh), 32'h0);
    checkOutput("post_rst_address", address, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
